// File: rtl/sr_cpu_run_ctrl_pkg.sv
// Shared types and default constants for the sr_cpu run controller.
package sr_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } run_state_t;

  localparam int          RST_CYCLES_DEF = 2;
  localparam int          TIMEOUT_DEF    = 1000;
  localparam logic [4:0]  A0_REG         = 5'd10;
  localparam logic [31:0] FIB_EXPECT     = 32'h00213d05;
  localparam logic [31:0] FACT_EXPECT    = 32'h1c8cfc00;

  function automatic logic is_match(input logic [31:0] d,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return (d == a) || (d == b);
  endfunction

endpackage

// File: rtl/sr_cpu_run_ctrl_if.sv
// Control, status and CPU debug-port bundle of the run controller.
interface sr_cpu_run_ctrl_if;
  logic        start;
  logic [31:0] expect_a;
  logic [31:0] expect_b;
  logic        cpu_rst;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        host_req;
  logic [4:0]  host_addr;
  logic        host_gnt;
  logic [31:0] host_data;
  logic        host_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] cycles;

  modport master (
    output start, expect_a, expect_b, dbg_data, host_req, host_addr,
    input  cpu_rst, dbg_addr, host_gnt, host_data, host_valid,
           busy, done, pass, cycles
  );

  modport slave (
    input  start, expect_a, expect_b, dbg_data, host_req, host_addr,
    output cpu_rst, dbg_addr, host_gnt, host_data, host_valid,
           busy, done, pass, cycles
  );
endinterface

// File: rtl/sr_cpu_run_ctrl_dbg_port_arb.sv
// Shares the CPU register debug port between the watcher and host reads.
module sr_dbg_port_arb
  import sr_run_ctrl_pkg::*;
#(
  parameter logic [4:0] WATCH_REG = A0_REG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_in_run,
  input  logic        i_host_req,
  input  logic [4:0]  i_host_addr,
  input  logic [31:0] i_dbg_data,
  output logic        o_host_gnt,
  output logic [4:0]  o_dbg_addr,
  output logic [31:0] o_host_data,
  output logic        o_host_valid
);
  logic r_last_sample;
  logic w_gnt;

  // In RUN the host only gets a slot right after a watch sample, so the
  // watcher never goes more than one cycle without looking.
  assign w_gnt        = i_in_run ? (i_host_req & r_last_sample) : i_host_req;
  assign o_host_gnt   = w_gnt;
  assign o_dbg_addr   = w_gnt ? i_host_addr : WATCH_REG;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_sample <= 1'b0;
      o_host_data   <= '0;
      o_host_valid  <= 1'b0;
    end else begin
      r_last_sample <= i_in_run & ~w_gnt;
      o_host_valid  <= w_gnt;
      if (w_gnt) o_host_data <= i_dbg_data;
    end
  end
endmodule

// File: rtl/sr_cpu_run_ctrl.sv
// Run controller: sequences CPU reset, bounds the run, watches a register.
module sr_cpu_run_ctrl
  import sr_run_ctrl_pkg::*;
#(
  parameter int         RST_CYCLES = RST_CYCLES_DEF,
  parameter int         TIMEOUT    = TIMEOUT_DEF,
  parameter logic [4:0] WATCH_REG  = A0_REG
) (
  input logic               clk,
  input logic               rst,
  sr_cpu_run_ctrl_if.slave  io_bus
);
  run_state_t  r_state, w_next;
  logic [31:0] r_exp_a, r_exp_b, r_cycles;
  logic [15:0] r_rst_cnt;
  logic        w_in_run, w_sample, w_match, w_timeout, w_start_ok, w_rst_last;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_sample   = w_in_run & ~io_bus.host_gnt;
  assign w_match    = w_sample & is_match(io_bus.dbg_data, r_exp_a, r_exp_b);
  assign w_timeout  = (r_cycles == 32'(TIMEOUT - 1));
  assign w_rst_last = (r_rst_cnt == 16'(RST_CYCLES - 1));
  assign w_start_ok = io_bus.start &
                      ((r_state == ST_IDLE) | (r_state == ST_PASS) | (r_state == ST_FAIL));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_PASS, ST_FAIL: if (io_bus.start) w_next = ST_RESET;
      ST_RESET:                  if (w_rst_last) w_next = ST_RUN;
      ST_RUN: begin
        // A match in the final budgeted cycle still counts as a pass.
        if (w_match)        w_next = ST_PASS;
        else if (w_timeout) w_next = ST_FAIL;
      end
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_exp_a   <= '0;
      r_exp_b   <= '0;
      r_cycles  <= '0;
      r_rst_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_exp_a  <= io_bus.expect_a;
        r_exp_b  <= io_bus.expect_b;
        r_cycles <= '0;
      end else if (w_in_run && r_cycles != '1) begin
        r_cycles <= r_cycles + 32'd1;
      end
      r_rst_cnt <= (r_state == ST_RESET) ? r_rst_cnt + 16'd1 : 16'd0;
    end
  end

  assign io_bus.cpu_rst = (r_state == ST_IDLE) | (r_state == ST_RESET);
  assign io_bus.busy    = (r_state == ST_RESET) | w_in_run;
  assign io_bus.done    = (r_state == ST_PASS) | (r_state == ST_FAIL);
  assign io_bus.pass    = (r_state == ST_PASS);
  assign io_bus.cycles  = r_cycles;

  sr_dbg_port_arb #(.WATCH_REG(WATCH_REG)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_in_run     (w_in_run),
    .i_host_req   (io_bus.host_req),
    .i_host_addr  (io_bus.host_addr),
    .i_dbg_data   (io_bus.dbg_data),
    .o_host_gnt   (io_bus.host_gnt),
    .o_dbg_addr   (io_bus.dbg_addr),
    .o_host_data  (io_bus.host_data),
    .o_host_valid (io_bus.host_valid)
  );
endmodule

// File: tb/tb_sr_cpu_run_ctrl.sv
// Directed bench for sr_cpu_run_ctrl with a tiny counting-CPU model.
module tb_sr_cpu_run_ctrl;
  import sr_run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a0;
  int          n_checks = 0;
  int          n_err    = 0;

  sr_cpu_run_ctrl_if bus ();

  sr_cpu_run_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  // CPU stand-in: a0 starts at 0x100 out of reset and counts up each cycle;
  // every other register reads as 0xA5A500nn.
  always @(posedge clk) a0 <= bus.cpu_rst ? 32'h100 : a0 + 32'd1;
  assign bus.dbg_data = (bus.dbg_addr == 5'd10) ? a0
                                                : (32'hA5A50000 | {27'd0, bus.dbg_addr});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] ea, input logic [31:0] eb);
    bus.expect_a = ea;
    bus.expect_b = eb;
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
    #1;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.expect_a  = '0;
    bus.expect_b  = '0;
    bus.host_req  = 1'b0;
    bus.host_addr = 5'd1;
    tick(2);
    rst = 1'b0;
    #1;

    chk("rst_cpu_rst", bus.cpu_rst, 1);
    chk("rst_dbg_addr", bus.dbg_addr, 10);
    chk("rst_host_gnt", bus.host_gnt, 0);
    chk("rst_host_valid", bus.host_valid, 0);
    chk("rst_host_data", bus.host_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_cycles", bus.cycles, 0);

    // Host read in IDLE: grant follows request directly
    bus.host_req = 1'b1;
    #1;
    chk("idle_gnt", bus.host_gnt, 1);
    chk("idle_addr", bus.dbg_addr, 1);
    tick(1);
    bus.host_req = 1'b0;
    #1;
    chk("idle_valid", bus.host_valid, 1);
    chk("idle_data", bus.host_data, 32'hA5A50001);
    tick(1);
    chk("idle_valid_drop", bus.host_valid, 0);

    // A: pass through expect_b, a0 == 0x107 in RUN cycle 7
    do_start(FIB_EXPECT, 32'h107);
    chk("a_busy", bus.busy, 1);
    chk("a_cpu_rst", bus.cpu_rst, 1);
    tick(2);
    chk("a_run_release", bus.cpu_rst, 0);
    chk("a_run_cycles0", bus.cycles, 0);
    tick(7);
    chk("a_not_done_yet", bus.done, 0);
    tick(1);
    chk("a_done", bus.done, 1);
    chk("a_pass", bus.pass, 1);
    chk("a_cycles", bus.cycles, 8);
    chk("a_cpu_runs", bus.cpu_rst, 0);

    // B: restart from PASS, never matches, times out; start mid-RUN ignored
    do_start(32'hdeadbeef, 32'h0);
    chk("b_done_clear", bus.done, 0);
    chk("b_reset_entry", bus.cpu_rst, 1);
    chk("b_cycles_clear", bus.cycles, 0);
    tick(1);
    chk("b_reset_hold", bus.cpu_rst, 1);
    tick(1);
    chk("b_release", bus.cpu_rst, 0);
    tick(10);
    chk("b_cycles10", bus.cycles, 10);
    do_start(32'h105, 32'h105);
    chk("b_start_ignored", bus.cycles, 11);
    chk("b_still_busy", bus.busy, 1);
    tick(988);
    chk("b_cycles999", bus.cycles, 999);
    chk("b_not_done", bus.done, 0);
    tick(1);
    chk("b_fail_done", bus.done, 1);
    chk("b_fail_pass", bus.pass, 0);
    chk("b_fail_cycles", bus.cycles, 1000);
    tick(3);
    chk("b_frozen", bus.cycles, 1000);

    // C: continuous host request; watcher samples even cycles only
    bus.host_req = 1'b1;
    do_start(32'h10A, 32'h105);
    tick(2);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("c_gnt%0d", k), bus.host_gnt, (k % 2 == 1));
      chk($sformatf("c_addr%0d", k), bus.dbg_addr, (k % 2 == 1) ? 5'd1 : 5'd10);
      chk($sformatf("c_valid%0d", k), bus.host_valid, (k % 2 == 0));
      if (k < 10) tick(1);
    end
    chk("c_data", bus.host_data, 32'hA5A50001);
    tick(1);
    chk("c_pass", bus.pass, 1);
    chk("c_cycles", bus.cycles, 11);
    bus.host_req = 1'b0;
    #1;

    // D: match lands exactly in the last budgeted RUN cycle
    do_start(32'h4E7, 32'hdeadbeef);
    tick(2);
    tick(999);
    chk("d_cycles999", bus.cycles, 999);
    chk("d_not_done", bus.done, 0);
    tick(1);
    chk("d_pass", bus.pass, 1);
    chk("d_done", bus.done, 1);
    chk("d_cycles", bus.cycles, 1000);

    // E: reset mid-RUN discards the run, then a fresh run
    do_start(32'h4E7, 32'hdeadbeef);
    tick(2);
    tick(5);
    chk("e_mid_run", bus.cycles, 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("e_idle_cpu_rst", bus.cpu_rst, 1);
    chk("e_idle_busy", bus.busy, 0);
    chk("e_idle_done", bus.done, 0);
    chk("e_idle_cycles", bus.cycles, 0);
    do_start(32'h103, 32'hdeadbeef);
    chk("e_busy", bus.busy, 1);
    tick(2);
    chk("e_cycles0", bus.cycles, 0);
    chk("e_release", bus.cpu_rst, 0);
    tick(4);
    chk("e_pass", bus.pass, 1);
    chk("e_cycles", bus.cycles, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
